cfg_tile_target: RTL and testbench

- Configuration-bus responder inside each CGRA tile.
- Accepts (address, data) words from the top-level config bus (config_addr_in/config_data_in), matches its tile ID, and writes them into shadow registers.
- On a commit command, atomically copies all shadow registers to the active registers that drive tile datapath and switch-box muxes.
- Sits between the top-level config distribution and each PE/switch-box.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/cfg_shadow_bank.sv | 70 +++++++
 rtl/cfg_tile_target.sv | 197 +++++++++++++++++++
 tb/tb_cfg_tile_target.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the tile configuration target.
//   - Bit positions of the tile ID, register index and op fields in config_addr_in.
//   - Op codes and the reserved commit index.
//   - The commit FSM state type.
//   - A saturating 8-bit increment helper for the error counter.
package cfg_pkg;

  localparam int TILE_MSB = 31;
  localparam int TILE_LSB = 16;
  localparam int IDX_MSB  = 15;
  localparam int IDX_LSB  = 8;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 0;

  localparam logic [7:0] CFG_OP_WRITE   = 8'h00;
  localparam logic [7:0] CFG_OP_READ    = 8'h01;
  localparam logic [7:0] CFG_IDX_COMMIT = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } cfg_state_t;

  // Counts up to 255 and then holds there instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cfg_shadow_bank.sv
// cfg_shadow_bank: shadow and active configuration register arrays.
//   clk_in, reset_in   : clock and asynchronous active-low reset
//   wr_en_in/wr_idx_in/wr_data_in : single write port into the shadow array
//   copy_en_in         : copies every shadow register into the active array
//   rd_idx_in/rd_data_out : combinational shadow read port (only with CFG_READBACK_EN)
//   active_flat_out    : active array flattened, reg i at [i*DATA_W +: DATA_W]
// Build option: CFG_READBACK_EN adds the shadow read port.
module cfg_shadow_bank
  import cfg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 3
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       wr_en_in,
  input  logic [IDX_W-1:0]           wr_idx_in,
  input  logic [DATA_W-1:0]          wr_data_in,
  input  logic                       copy_en_in,
`ifdef CFG_READBACK_EN
  input  logic [IDX_W-1:0]           rd_idx_in,
  output logic [DATA_W-1:0]          rd_data_out,
`endif
  output logic [NUM_REGS*DATA_W-1:0] active_flat_out
);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] active_d [NUM_REGS];

  // Writes and the copy both work from the current shadow contents, so a
  // copy on the same edge as a write would snapshot the pre-write value.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_in) begin
      shadow_d[wr_idx_in] = wr_data_in;
    end
  end

  always_comb begin
    if (copy_en_in) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

`ifdef CFG_READBACK_EN
  assign rd_data_out = shadow_q[rd_idx_in];
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign active_flat_out[g*DATA_W +: DATA_W] = active_q[g];
  end

endmodule

// File: rtl/cfg_tile_target.sv
// cfg_tile_target: per-tile configuration bus responder.
//   clk_in, reset_in      : clock and asynchronous active-low reset
//   config_addr_in        : [31:16] tile ID, [15:8] register index, [7:0] op
//   config_data_in        : write data (low DATA_W bits used)
//   config_valid_in       : a word is present on the bus this cycle
//   config_ready_out      : the target accepts the word this cycle
//   cfg_regs_out          : active registers, reg i at [i*DATA_W +: DATA_W]
//   cfg_committed_out     : one-cycle pulse after the active registers update
//   cfg_err_count_out     : saturating count of malformed words for this tile
//   config_read_data_out  : shadow readback data
//   config_read_valid_out : one-cycle readback strobe
// Build option: CFG_READBACK_EN enables op 01 shadow readback; without it the
// read outputs are tied low and op 01 is counted as malformed.
//
// Words land in a one-entry holding register and are decoded on the following
// edge while the FSM is IDLE. A commit command moves the FSM to COMMIT for one
// cycle; leaving COMMIT copies shadow to active.
module cfg_tile_target
  import cfg_pkg::*;
#(
  parameter logic [15:0] TILE_ID  = 16'h0000,
  parameter int          NUM_REGS = 8,
  parameter int          DATA_W   = 32
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [31:0]                config_addr_in,
  input  logic [31:0]                config_data_in,
  input  logic                       config_valid_in,
  output logic                       config_ready_out,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs_out,
  output logic                       cfg_committed_out,
  output logic [7:0]                 cfg_err_count_out,
  output logic [DATA_W-1:0]          config_read_data_out,
  output logic                       config_read_valid_out
);

  localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NUM_REGS_9 = 9'(NUM_REGS);

  cfg_state_t        state_q, state_d;
  logic              s1_full_q, s1_full_d;
  logic [31:0]       s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              committed_q, committed_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              accept;
  logic              stage2_blocked;
  logic              decode_en;
  logic [15:0]       dec_tile;
  logic [7:0]        dec_idx;
  logic [7:0]        dec_op;
  logic              tile_match;
  logic              idx_in_range;
  logic              good_write;
  logic              commit_word;
  logic              good_read;
  logic              bad_word;
  logic              copy_en;

  // Stage 2 only decodes in IDLE; during COMMIT a held word must wait so it
  // lands in shadow after the copy.
  assign stage2_blocked   = (state_q != IDLE);
  assign config_ready_out = (state_q != COMMIT) && !(s1_full_q && stage2_blocked);
  assign accept           = config_valid_in && config_ready_out;
  assign decode_en        = s1_full_q && (state_q == IDLE);

  assign dec_tile     = s1_addr_q[TILE_MSB:TILE_LSB];
  assign dec_idx      = s1_addr_q[IDX_MSB:IDX_LSB];
  assign dec_op       = s1_addr_q[OP_MSB:OP_LSB];
  assign tile_match   = (dec_tile == TILE_ID);
  assign idx_in_range = ({1'b0, dec_idx} < NUM_REGS_9);

  assign good_write  = (dec_op == CFG_OP_WRITE) && idx_in_range;
  // The commit index is a valid command whatever data[0] says; only the
  // transition to COMMIT depends on it.
  assign commit_word = (dec_op == CFG_OP_WRITE) && (dec_idx == CFG_IDX_COMMIT);
`ifdef CFG_READBACK_EN
  assign good_read   = (dec_op == CFG_OP_READ) && idx_in_range;
`else
  assign good_read   = 1'b0;
`endif
  assign bad_word    = decode_en && tile_match && !(good_write || commit_word || good_read);

  assign copy_en = (state_q == COMMIT);

  // Holding register: a new word can load on the same edge the previous one
  // is decoded, which keeps one word per cycle outside of commits.
  always_comb begin
    s1_full_d = s1_full_q;
    s1_addr_d = s1_addr_q;
    s1_data_d = s1_data_q;
    if (accept) begin
      s1_full_d = 1'b1;
      s1_addr_d = config_addr_in;
      s1_data_d = config_data_in[DATA_W-1:0];
    end else if (decode_en) begin
      s1_full_d = 1'b0;
    end
  end

  // Commit FSM, committed pulse and error counter next-state.
  always_comb begin
    state_d     = state_q;
    committed_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (decode_en && tile_match && commit_word && s1_data_q[0]) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d     = IDLE;
        committed_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bad_word) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= IDLE;
      s1_full_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      committed_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s1_full_q   <= s1_full_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      committed_q <= committed_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cfg_committed_out = committed_q;
  assign cfg_err_count_out = err_cnt_q;

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] bank_rd_data;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              read_en;

  assign read_en = decode_en && tile_match && good_read;

  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = read_en;
    if (read_en) begin
      read_data_d = bank_rd_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign config_read_data_out  = read_data_q;
  assign config_read_valid_out = read_valid_q;
`else
  assign config_read_data_out  = '0;
  assign config_read_valid_out = 1'b0;
`endif

  cfg_shadow_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .wr_en_in        (decode_en && tile_match && good_write),
    .wr_idx_in       (dec_idx[IDX_W-1:0]),
    .wr_data_in      (s1_data_q),
    .copy_en_in      (copy_en),
`ifdef CFG_READBACK_EN
    .rd_idx_in       (dec_idx[IDX_W-1:0]),
    .rd_data_out     (bank_rd_data),
`endif
    .active_flat_out (cfg_regs_out)
  );

endmodule

// File: tb/tb_cfg_tile_target.sv
// tb_cfg_tile_target: directed test of cfg_tile_target with TILE_ID=5,
// NUM_REGS=8, DATA_W=32. Expected values are hand-computed per scenario.
// Build option: CFG_READBACK_EN switches the readback expectations.
module tb_cfg_tile_target;

  localparam int NR = 8;
  localparam int DW = 32;

  logic              clk_in;
  logic              reset_in;
  logic [31:0]       config_addr_in;
  logic [31:0]       config_data_in;
  logic              config_valid_in;
  logic              config_ready_out;
  logic [NR*DW-1:0]  cfg_regs_out;
  logic              cfg_committed_out;
  logic [7:0]        cfg_err_count_out;
  logic [DW-1:0]     config_read_data_out;
  logic              config_read_valid_out;

  int checks   = 0;
  int failures = 0;

  cfg_tile_target #(
    .TILE_ID  (16'h0005),
    .NUM_REGS (NR),
    .DATA_W   (DW)
  ) dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .config_addr_in        (config_addr_in),
    .config_data_in        (config_data_in),
    .config_valid_in       (config_valid_in),
    .config_ready_out      (config_ready_out),
    .cfg_regs_out          (cfg_regs_out),
    .cfg_committed_out     (cfg_committed_out),
    .cfg_err_count_out     (cfg_err_count_out),
    .config_read_data_out  (config_read_data_out),
    .config_read_valid_out (config_read_valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] reg_at(input int i);
    return cfg_regs_out[i*DW +: DW];
  endfunction

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    config_valid_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    config_addr_in  = a;
    config_data_in  = d;
    config_valid_in = 1'b1;
    step();
    config_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    config_valid_in = 1'b0;
    reset_in = 1'b0;
    repeat (2) step();
    reset_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    config_valid_in = 1'b0;
    config_addr_in  = '0;
    config_data_in  = '0;
    reset_in = 1'b0;
    repeat (2) step();
    checks++;
    if (cfg_regs_out !== '0) begin
      failures++; $display("[TB] FAIL reset_regs: got %0h expected 0", cfg_regs_out);
    end
    checks++;
    if (cfg_committed_out !== 1'b0 || config_read_valid_out !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pulses: got %b%b expected 00", cfg_committed_out, config_read_valid_out);
    end
    checks++;
    if (cfg_err_count_out !== 8'd0 || config_read_data_out !== '0) begin
      failures++; $display("[TB] FAIL reset_err_rd: got %0d/%0h expected 0/0", cfg_err_count_out, config_read_data_out);
    end
    reset_in = 1'b1;
    step();
    checks++;
    if (config_ready_out !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready: got %b expected 1", config_ready_out);
    end
  endtask

  task automatic test_basic_commit();
    do_reset();
    send(32'h0005_0200, 32'd3);
    send(32'h0005_FF00, 32'd1);
    idle(1);
    checks++;
    if (config_ready_out !== 1'b0 || reg_at(2) !== 32'd0 || cfg_committed_out !== 1'b0) begin
      failures++; $display("[TB] FAIL commit_cycle: got rdy=%b r2=%0h pulse=%b expected rdy=0 r2=0 pulse=0",
                           config_ready_out, reg_at(2), cfg_committed_out);
    end
    idle(1);
    checks++;
    if (reg_at(2) !== 32'd3) begin
      failures++; $display("[TB] FAIL commit_r2: got %0h expected 3", reg_at(2));
    end
    checks++;
    if (cfg_committed_out !== 1'b1) begin
      failures++; $display("[TB] FAIL commit_pulse: got %b expected 1", cfg_committed_out);
    end
    for (int i = 0; i < NR; i++) begin
      if (i != 2) begin
        checks++;
        if (reg_at(i) !== 32'd0) begin
          failures++; $display("[TB] FAIL commit_other_r%0d: got %0h expected 0", i, reg_at(i));
        end
      end
    end
    idle(1);
    checks++;
    if (cfg_committed_out !== 1'b0 || reg_at(2) !== 32'd3) begin
      failures++; $display("[TB] FAIL commit_after: got pulse=%b r2=%0h expected pulse=0 r2=3", cfg_committed_out, reg_at(2));
    end
  endtask

  task automatic test_tile_mismatch();
    do_reset();
    send(32'h0006_0000, 32'd7);
    send(32'h0005_FF00, 32'd1);
    idle(2);
    checks++;
    if (cfg_committed_out !== 1'b1) begin
      failures++; $display("[TB] FAIL mismatch_pulse: got %b expected 1", cfg_committed_out);
    end
    checks++;
    if (cfg_regs_out !== '0) begin
      failures++; $display("[TB] FAIL mismatch_regs: got %0h expected 0", cfg_regs_out);
    end
    checks++;
    if (cfg_err_count_out !== 8'd0) begin
      failures++; $display("[TB] FAIL mismatch_err: got %0d expected 0", cfg_err_count_out);
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    send(32'h0005_0400, 32'd1);
    send(32'h0005_0400, 32'd2);
    send(32'h0005_FF00, 32'd1);
    idle(2);
    checks++;
    if (reg_at(4) !== 32'd2 || cfg_committed_out !== 1'b1) begin
      failures++; $display("[TB] FAIL overwrite_r4: got r4=%0h pulse=%b expected r4=2 pulse=1", reg_at(4), cfg_committed_out);
    end
  endtask

  task automatic test_stream();
    logic [31:0] waddr [3];
    logic [31:0] wdata [3];
    int k = 0;
    int lows = 0;
    int pulses = 0;
    logic [31:0] r0_at_pulse = 32'hFFFF_FFFF;
    logic rdy;
    waddr[0] = 32'h0005_0000; wdata[0] = 32'd1;
    waddr[1] = 32'h0005_FF00; wdata[1] = 32'd1;
    waddr[2] = 32'h0005_0000; wdata[2] = 32'd2;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (k < 3) begin
        config_addr_in  = waddr[k];
        config_data_in  = wdata[k];
        config_valid_in = 1'b1;
      end else begin
        config_valid_in = 1'b0;
      end
      rdy = config_ready_out;
      if (!rdy) lows++;
      step();
      if (rdy && k < 3) k++;
      if (cfg_committed_out) begin
        pulses++;
        r0_at_pulse = reg_at(0);
      end
    end
    config_valid_in = 1'b0;
    checks++;
    if (k !== 3) begin
      failures++; $display("[TB] FAIL stream_accepted: got %0d expected 3", k);
    end
    checks++;
    if (lows !== 1) begin
      failures++; $display("[TB] FAIL stream_ready_low: got %0d expected 1", lows);
    end
    checks++;
    if (pulses !== 1 || r0_at_pulse !== 32'd1) begin
      failures++; $display("[TB] FAIL stream_first_commit: got pulses=%0d r0=%0h expected 1/1", pulses, r0_at_pulse);
    end
    checks++;
    if (reg_at(0) !== 32'd1) begin
      failures++; $display("[TB] FAIL stream_active_r0: got %0h expected 1", reg_at(0));
    end
    send(32'h0005_FF00, 32'd1);
    idle(2);
    checks++;
    if (reg_at(0) !== 32'd2) begin
      failures++; $display("[TB] FAIL stream_second_commit_r0: got %0h expected 2", reg_at(0));
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic prev = 1'b0;
    int adjacent = 0;
    do_reset();
    send(32'h0005_0700, 32'hA5);
    send(32'h0005_FF00, 32'd1);
    send(32'h0005_FF00, 32'd1);
    config_valid_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (cfg_committed_out) pulses++;
      if (cfg_committed_out && prev) adjacent++;
      prev = cfg_committed_out;
    end
    checks++;
    if (pulses !== 2 || adjacent !== 0) begin
      failures++; $display("[TB] FAIL b2b_pulses: got %0d (adjacent %0d) expected 2 (0)", pulses, adjacent);
    end
    checks++;
    if (reg_at(7) !== 32'hA5) begin
      failures++; $display("[TB] FAIL b2b_r7: got %0h expected a5", reg_at(7));
    end
  endtask

  task automatic test_reset_during_commit();
    int pulses = 0;
    do_reset();
    send(32'h0005_0100, 32'h55);
    send(32'h0005_FF00, 32'd1);
    idle(1);
    checks++;
    if (config_ready_out !== 1'b0) begin
      failures++; $display("[TB] FAIL rdc_in_commit: got rdy=%b expected 0", config_ready_out);
    end
    #2 reset_in = 1'b0;
    @(posedge clk_in);
    #1;
    checks++;
    if (cfg_regs_out !== '0 || cfg_committed_out !== 1'b0) begin
      failures++; $display("[TB] FAIL rdc_aborted: got regs=%0h pulse=%b expected 0/0", cfg_regs_out, cfg_committed_out);
    end
    reset_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (cfg_committed_out) pulses++;
    end
    checks++;
    if (pulses !== 0 || config_ready_out !== 1'b1 || cfg_regs_out !== '0) begin
      failures++; $display("[TB] FAIL rdc_release: got pulses=%0d rdy=%b regs=%0h expected 0/1/0",
                           pulses, config_ready_out, cfg_regs_out);
    end
    send(32'h0005_FF00, 32'd1);
    idle(2);
    checks++;
    if (cfg_committed_out !== 1'b1 || reg_at(1) !== 32'd0) begin
      failures++; $display("[TB] FAIL rdc_shadow_cleared: got pulse=%b r1=%0h expected 1/0", cfg_committed_out, reg_at(1));
    end
  endtask

  task automatic test_readback();
    do_reset();
    send(32'h0005_0300, 32'hDEAD_BEEF);
    send(32'h0005_0301, 32'd0);
    idle(1);
`ifdef CFG_READBACK_EN
    checks++;
    if (config_read_valid_out !== 1'b1 || config_read_data_out !== 32'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL readback_data: got v=%b d=%0h expected v=1 d=deadbeef",
                           config_read_valid_out, config_read_data_out);
    end
    checks++;
    if (cfg_err_count_out !== 8'd0) begin
      failures++; $display("[TB] FAIL readback_err: got %0d expected 0", cfg_err_count_out);
    end
`else
    checks++;
    if (config_read_valid_out !== 1'b0 || config_read_data_out !== 32'd0) begin
      failures++; $display("[TB] FAIL readback_tied: got v=%b d=%0h expected 0/0",
                           config_read_valid_out, config_read_data_out);
    end
    checks++;
    if (cfg_err_count_out !== 8'd1) begin
      failures++; $display("[TB] FAIL readback_err: got %0d expected 1", cfg_err_count_out);
    end
`endif
    idle(1);
    checks++;
    if (config_read_valid_out !== 1'b0) begin
      failures++; $display("[TB] FAIL readback_pulse_end: got %b expected 0", config_read_valid_out);
    end
    send(32'h0005_0901, 32'd0);
    idle(1);
    checks++;
`ifdef CFG_READBACK_EN
    if (cfg_err_count_out !== 8'd1) begin
      failures++; $display("[TB] FAIL readback_oor_err: got %0d expected 1", cfg_err_count_out);
    end
`else
    if (cfg_err_count_out !== 8'd2) begin
      failures++; $display("[TB] FAIL readback_oor_err: got %0d expected 2", cfg_err_count_out);
    end
`endif
  endtask

  task automatic test_errors();
    do_reset();
    send(32'h0005_FF00, 32'd0);
    idle(2);
    checks++;
    if (cfg_committed_out !== 1'b0 || cfg_err_count_out !== 8'd0) begin
      failures++; $display("[TB] FAIL commit_noop: got pulse=%b err=%0d expected 0/0", cfg_committed_out, cfg_err_count_out);
    end
    send(32'h0005_0900, 32'd0);
    idle(1);
    checks++;
    if (cfg_err_count_out !== 8'd1) begin
      failures++; $display("[TB] FAIL err_idx9: got %0d expected 1", cfg_err_count_out);
    end
    for (int i = 0; i < 253; i++) begin
      send((i % 2 == 0) ? 32'h0005_0902 : 32'h0005_1000, i);
    end
    idle(1);
    checks++;
    if (cfg_err_count_out !== 8'd254) begin
      failures++; $display("[TB] FAIL err_254: got %0d expected 254", cfg_err_count_out);
    end
    for (int i = 0; i < 47; i++) begin
      send(32'h0005_2000, i);
    end
    idle(1);
    checks++;
    if (cfg_err_count_out !== 8'd255) begin
      failures++; $display("[TB] FAIL err_saturate: got %0d expected 255", cfg_err_count_out);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    config_valid_in = 1'b0;
    config_addr_in  = '0;
    config_data_in  = '0;
    test_reset();
    test_basic_commit();
    test_tile_mismatch();
    test_overwrite();
    test_stream();
    test_back_to_back();
    test_reset_during_commit();
    test_readback();
    test_errors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
